// File: rtl/dynamixel_status_if.sv
// Bus-side and result signals of the Dynamixel 2.0 status receiver, plus debug state taps.
// status_valid, crc_error and frame_error are single-cycle strobes with no ready: the consumer must capture results on the strobe cycle.
interface dynamixel_status_if;
    logic        pin;
    logic        enable;
    logic        status_valid;
    logic [7:0]  status_id;
    logic [7:0]  status_error;
    logic [31:0] status_value;
    logic [15:0] param_count;
    logic        crc_error;
    logic        frame_error;
    logic [1:0]  dbg_uart_state;
    logic [3:0]  dbg_parser_state;

    modport master (
        output pin, enable,
        input  status_valid, status_id, status_error, status_value, param_count,
        input  crc_error, frame_error, dbg_uart_state, dbg_parser_state
    );

    modport slave (
        input  pin, enable,
        output status_valid, status_id, status_error, status_value, param_count,
        output crc_error, frame_error, dbg_uart_state, dbg_parser_state
    );
endinterface

// File: rtl/dynamixel_status_receiver.sv
// Dynamixel 2.0 status packet receiver: 8N1 UART, header/length parser, CRC-16 check.
// Optional byte unstuffing of PARAM data is enabled by defining DYNAMIXEL_RX_UNSTUFF_EN.
module dynamixel_status_receiver #(
    parameter int clocks_per_bit = 3,
    parameter int timeout_bits   = 100
) (
    input  logic               clock,
    input  logic               reset,
    dynamixel_status_if.slave  bus
);
    localparam int half_bit       = clocks_per_bit / 2;
    localparam int timeout_cycles = timeout_bits * clocks_per_bit;
    localparam int bit_cnt_w      = $clog2(clocks_per_bit + 1);
    localparam int tmo_w          = $clog2(timeout_cycles + 1);

    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;
    typedef enum logic [3:0] {
        P_HDR1, P_HDR2, P_HDR3, P_RSV, P_ID, P_LEN_L, P_LEN_H,
        P_INST, P_ERR, P_PARAM, P_CRC_L, P_CRC_H
    } parser_state_t;

    function automatic logic [15:0] crc_update(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h8005;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    // pin synchronizer; rx_prev gives the falling-edge reference for start detection
    logic sync_0, sync_1, rx_prev;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_0  <= 1'b1;
            sync_1  <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync_0  <= bus.pin;
            sync_1  <= sync_0;
            rx_prev <= sync_1;
        end
    end

    uart_state_t            u_state, u_next;
    logic [bit_cnt_w-1:0]   bit_cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             shift_reg;
    logic                   half_tick, full_tick, byte_strobe, stop_ok;

    assign half_tick = (bit_cnt == bit_cnt_w'(half_bit - 1));
    assign full_tick = (bit_cnt == bit_cnt_w'(clocks_per_bit - 1));
    assign stop_ok   = sync_1;

    always_comb begin
        u_next      = u_state;
        byte_strobe = 1'b0;
        case (u_state)
            U_IDLE:  if (rx_prev && !sync_1) u_next = U_START;
            U_START: if (half_tick) u_next = sync_1 ? U_IDLE : U_DATA;
            U_DATA:  if (full_tick && bit_idx == 3'd7) u_next = U_STOP;
            U_STOP:  if (full_tick) begin
                         u_next      = U_IDLE;
                         byte_strobe = 1'b1;
                     end
        endcase
        if (!bus.enable) begin
            u_next      = U_IDLE;
            byte_strobe = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            u_state   <= U_IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            u_state <= u_next;
            if (u_state == U_IDLE || u_next != u_state || full_tick) bit_cnt <= '0;
            else bit_cnt <= bit_cnt + bit_cnt_w'(1);
            if (u_state == U_START) bit_idx <= '0;
            else if (u_state == U_DATA && full_tick) begin
                bit_idx   <= bit_idx + 3'd1;
                shift_reg <= {sync_1, shift_reg[7:1]};
            end
        end
    end

    parser_state_t   p_state, p_next;
    logic [7:0]      len_low, crc_low, pkt_id, pkt_err;
    logic [15:0]     param_left, work_count, crc_acc;
    logic [31:0]     work_value;
    logic [tmo_w-1:0] tmo_cnt;
    logic            timeout_hit, good_byte, stuffed;
    logic            pulse_valid, pulse_crc, pulse_frame;
    logic            valid_q, crc_err_q, frame_err_q;
    logic [7:0]      out_id, out_err;
    logic [31:0]     out_value;
    logic [15:0]     out_count;

    assign timeout_hit = (tmo_cnt == tmo_w'(timeout_cycles - 1));
    assign good_byte   = byte_strobe && stop_ok;

`ifdef DYNAMIXEL_RX_UNSTUFF_EN
    // last three transmitted bytes, used to spot the FD that follows FF FF FD
    logic [23:0] history;
    assign stuffed = (p_state == P_PARAM) && (shift_reg == 8'hFD) && (history == 24'hFFFFFD);
    always_ff @(posedge clock or posedge reset) begin
        if (reset)          history <= '0;
        else if (good_byte) history <= {history[15:0], shift_reg};
    end
`else
    assign stuffed = 1'b0;
`endif

    always_comb begin
        p_next      = p_state;
        pulse_valid = 1'b0;
        pulse_crc   = 1'b0;
        pulse_frame = 1'b0;
        if (!bus.enable) begin
            p_next = P_HDR1;
        end else if (byte_strobe && !stop_ok) begin
            p_next      = P_HDR1;
            pulse_frame = 1'b1;
        end else if (byte_strobe) begin
            case (p_state)
                P_HDR1:  p_next = (shift_reg == 8'hFF) ? P_HDR2 : P_HDR1;
                P_HDR2:  p_next = (shift_reg == 8'hFF) ? P_HDR3 : P_HDR1;
                P_HDR3:  p_next = (shift_reg == 8'hFD) ? P_RSV :
                                  (shift_reg == 8'hFF) ? P_HDR3 : P_HDR1;
                P_RSV:   p_next = (shift_reg == 8'h00) ? P_ID : P_HDR1;
                P_ID:    p_next = P_LEN_L;
                P_LEN_L: p_next = P_LEN_H;
                P_LEN_H: if ({shift_reg, len_low} < 16'd4) begin
                             p_next      = P_HDR1;
                             pulse_frame = 1'b1;
                         end else p_next = P_INST;
                P_INST:  if (shift_reg == 8'h55) p_next = P_ERR;
                         else begin
                             p_next      = P_HDR1;
                             pulse_frame = 1'b1;
                         end
                P_ERR:   p_next = (param_left == 16'd0) ? P_CRC_L : P_PARAM;
                P_PARAM: p_next = (param_left == 16'd1) ? P_CRC_L : P_PARAM;
                P_CRC_L: p_next = P_CRC_H;
                P_CRC_H: begin
                             p_next = P_HDR1;
                             if ({shift_reg, crc_low} == crc_acc) pulse_valid = 1'b1;
                             else                                 pulse_crc   = 1'b1;
                         end
                default: p_next = P_HDR1;
            endcase
        end else if (p_state != P_HDR1 && timeout_hit) begin
            p_next      = P_HDR1;
            pulse_frame = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            p_state     <= P_HDR1;
            valid_q     <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            tmo_cnt     <= '0;
            len_low     <= '0;
            crc_low     <= '0;
            pkt_id      <= '0;
            pkt_err     <= '0;
            param_left  <= '0;
            work_count  <= '0;
            work_value  <= '0;
            crc_acc     <= '0;
            out_id      <= '0;
            out_err     <= '0;
            out_value   <= '0;
            out_count   <= '0;
        end else begin
            p_state     <= p_next;
            valid_q     <= pulse_valid;
            crc_err_q   <= pulse_crc;
            frame_err_q <= pulse_frame;
            if (byte_strobe || p_state == P_HDR1 || !bus.enable || pulse_frame) tmo_cnt <= '0;
            else tmo_cnt <= tmo_cnt + tmo_w'(1);

            if (good_byte) begin
                // CRC restarts on the first FF; a repeated FF in HDR3 re-anchors it on the last FF FF
                case (p_state)
                    P_HDR1:           crc_acc <= crc_update(16'h0000, shift_reg);
                    P_HDR3:           crc_acc <= (shift_reg == 8'hFF) ?
                                          crc_update(crc_update(16'h0000, 8'hFF), 8'hFF) :
                                          crc_update(crc_acc, shift_reg);
                    P_CRC_L, P_CRC_H: ;
                    default:          crc_acc <= crc_update(crc_acc, shift_reg);
                endcase
                case (p_state)
                    P_ID: begin
                        pkt_id     <= shift_reg;
                        work_value <= '0;
                        work_count <= '0;
                    end
                    P_LEN_L: len_low    <= shift_reg;
                    P_LEN_H: param_left <= {shift_reg, len_low} - 16'd4;
                    P_ERR:   pkt_err    <= shift_reg;
                    P_PARAM: begin
                        param_left <= param_left - 16'd1;
                        if (!stuffed) begin
                            work_count <= work_count + 16'd1;
                            case (work_count)
                                16'd0:   work_value[7:0]   <= shift_reg;
                                16'd1:   work_value[15:8]  <= shift_reg;
                                16'd2:   work_value[23:16] <= shift_reg;
                                16'd3:   work_value[31:24] <= shift_reg;
                                default: ;
                            endcase
                        end
                    end
                    P_CRC_L: crc_low <= shift_reg;
                    default: ;
                endcase
            end

            if (pulse_valid) begin
                out_id    <= pkt_id;
                out_err   <= pkt_err;
                out_value <= work_value;
                out_count <= work_count;
            end
        end
    end

    assign bus.status_valid     = valid_q;
    assign bus.crc_error        = crc_err_q;
    assign bus.frame_error      = frame_err_q;
    assign bus.status_id        = out_id;
    assign bus.status_error     = out_err;
    assign bus.status_value     = out_value;
    assign bus.param_count      = out_count;
    assign bus.dbg_uart_state   = u_state;
    assign bus.dbg_parser_state = p_state;
endmodule

// File: tb/tb_dynamixel_status_receiver.sv
// Directed bench for dynamixel_status_receiver: packet-level model feeds an expected-event queue
// that a per-cycle compare process checks against the DUT strobes and held outputs.
module tb_dynamixel_status_receiver;
    localparam int cpb = 3;
    localparam int W   = 66;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    dynamixel_status_if bus ();

    dynamixel_status_receiver #(.clocks_per_bit(cpb), .timeout_bits(100)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];
    bit   [7:0]   pkt[$];
    bit   [7:0]   params[$];
    bit   [7:0]   stream[$];
    logic         checking = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- packet-level model ----------------
    function automatic logic [15:0] model_crc(input int n);
        logic [15:0] r;
        logic        top;
        r = 16'h0000;
        for (int i = 0; i < n; i++) begin
            for (int b = 7; b >= 0; b--) begin
                top = r[15] ^ pkt[i][b];
                r   = {r[14:0], 1'b0};
                if (top) r = r ^ 16'h8005;
            end
        end
        return r;
    endfunction

    task automatic build_packet(input logic [7:0] id, input logic [7:0] err);
        int          len;
        logic [15:0] c;
        len = params.size() + 4;
        pkt.delete();
        pkt.push_back(8'hFF); pkt.push_back(8'hFF); pkt.push_back(8'hFD); pkt.push_back(8'h00);
        pkt.push_back(id);
        pkt.push_back(len[7:0]); pkt.push_back(len[15:8]);
        pkt.push_back(8'h55); pkt.push_back(err);
        foreach (params[i]) pkt.push_back(params[i]);
        c = model_crc(pkt.size());
        pkt.push_back(c[7:0]); pkt.push_back(c[15:8]);
    endtask

    // Predicts the single outcome of pkt, given which byte (if any) carries a low stop bit.
    task automatic expect_packet(input int bad_stop);
        int          len, last, cnt;
        logic [15:0] calc, got;
        logic [31:0] val;
        len = (pkt.size() > 6) ? int'({pkt[6], pkt[5]}) : 0;
        for (int i = 0; i < pkt.size(); i++) begin
            if (i == bad_stop || (i == 6 && len < 4) || (i == 7 && pkt[7] != 8'h55)) begin
                exp_q.push_back({2'd3, 64'h0});
                return;
            end
        end
        last = 6 + len;
        calc = model_crc(last - 1);
        got  = {pkt[last], pkt[last-1]};
        if (calc != got) begin
            exp_q.push_back({2'd2, 64'h0});
            return;
        end
        val = '0;
        cnt = 0;
        for (int i = 9; i <= last - 2; i++) begin
`ifdef DYNAMIXEL_RX_UNSTUFF_EN
            if (pkt[i] == 8'hFD && pkt[i-3] == 8'hFF && pkt[i-2] == 8'hFF && pkt[i-1] == 8'hFD) continue;
`endif
            if (cnt < 4) val[8*cnt +: 8] = pkt[i];
            cnt++;
        end
        exp_q.push_back({2'd1, pkt[4], pkt[8], val, 16'(cnt)});
    endtask

    // ---------------- drivers ----------------
    task automatic drive_bit(input logic v);
        bus.pin = v;
        repeat (cpb) @(posedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic send_pkt(input int bad_stop, input int upto);
        for (int i = 0; i < upto; i++) send_byte(pkt[i], i != bad_stop);
    endtask

    task automatic idle_bits(input int n);
        bus.pin = 1'b1;
        repeat (n * cpb) @(posedge clock);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s: %0d expected events never seen", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic load_example();
        pkt = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h07, 8'h00, 8'h55,
                8'h00, 8'h06, 8'h04, 8'h26, 8'h65, 8'h5D};
    endtask

    task automatic send_good(input string name);
        load_example();
        expect_packet(-1);
        send_pkt(-1, pkt.size());
        idle_bits(3);
        drain(name);
    endtask

    // ---------------- scoreboard compare process ----------------
    logic [7:0]   hold_id, hold_err;
    logic [31:0]  hold_val;
    logic [15:0]  hold_cnt;
    logic [W-1:0] cur_ev;
    logic [1:0]   act_kind;
    logic [2:0]   pulses;

    always @(negedge clock) begin
        if (reset) begin
            hold_id  = '0;
            hold_err = '0;
            hold_val = '0;
            hold_cnt = '0;
        end else if (checking) begin
            pulses = {bus.status_valid, bus.crc_error, bus.frame_error};
            if (pulses != 3'b000) begin
                act_kind = (pulses == 3'b100) ? 2'd1 : (pulses == 3'b010) ? 2'd2 :
                           (pulses == 3'b001) ? 2'd3 : 2'd0;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse: got valid/crc/frame=%b expected none at %0t", pulses, $time);
                end else begin
                    cur_ev = exp_q.pop_front();
                    check("pulse_kind", 64'(act_kind), 64'(cur_ev[65:64]));
                    if (cur_ev[65:64] == 2'd1) begin
                        check("valid_data", {bus.status_id, bus.status_error, bus.status_value, bus.param_count},
                              cur_ev[63:0]);
                        {hold_id, hold_err, hold_val, hold_cnt} = cur_ev[63:0];
                    end
                end
            end
            check("held_outputs", {bus.status_id, bus.status_error, bus.status_value, bus.param_count},
                  {hold_id, hold_err, hold_val, hold_cnt});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    logic [W-1:0] last_ev;

    initial begin
        bus.pin    = 1'b1;
        bus.enable = 1'b1;
        reset      = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check("reset_data", {bus.status_id, bus.status_error, bus.status_value, bus.param_count}, 64'h0);
        check("reset_pulses", 64'({bus.status_valid, bus.crc_error, bus.frame_error}), 64'h0);
        reset = 1'b0;
        @(posedge clock);
        checking = 1'b1;
        idle_bits(2);

        // reference packet, with literal pins on the model
        load_example();
        check("model_crc_example", 64'(model_crc(12)), 64'h5D65);
        expect_packet(-1);
        last_ev = exp_q[exp_q.size()-1];
        check("model_example_kind", 64'(last_ev[65:64]), 64'd1);
        check("model_example_data", last_ev[63:0], {8'h01, 8'h00, 32'h00260406, 16'd3});
        send_pkt(-1, pkt.size());
        idle_bits(3);
        drain("good_example");

        // corrupted CRC byte
        load_example();
        pkt[12] = 8'h64;
        expect_packet(-1);
        send_pkt(-1, pkt.size());
        idle_bits(3);
        drain("crc_error");

        // low stop bit on the ID byte, then a clean packet
        load_example();
        expect_packet(4);
        send_pkt(4, 5);
        idle_bits(3);
        drain("stop_bit_error");
        send_good("after_stop_error");

        // 101 idle bit-times after LEN_H
        load_example();
        exp_q.push_back({2'd3, 64'h0});
        send_pkt(-1, 7);
        idle_bits(101);
        drain("timeout");
        send_good("after_timeout");

        // LEN below 4
        pkt = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h03, 8'h00};
        expect_packet(-1);
        send_pkt(-1, pkt.size());
        idle_bits(3);
        drain("len_too_small");

        // wrong instruction byte
        load_example();
        pkt[7] = 8'h54;
        expect_packet(-1);
        send_pkt(-1, pkt.size());
        idle_bits(3);
        drain("bad_inst");

        // parameters containing FF FF FD FD
        params = '{8'hFF, 8'hFF, 8'hFD, 8'hFD, 8'h10};
        build_packet(8'h02, 8'h00);
        expect_packet(-1);
        last_ev = exp_q[exp_q.size()-1];
`ifdef DYNAMIXEL_RX_UNSTUFF_EN
        check("model_stuff_data", last_ev[63:0], {8'h02, 8'h00, 32'h10FDFFFF, 16'd4});
`else
        check("model_stuff_data", last_ev[63:0], {8'h02, 8'h00, 32'hFDFDFFFF, 16'd5});
`endif
        send_pkt(-1, pkt.size());
        idle_bits(3);
        drain("stuffing");

        // two packets with zero idle gap
        params = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        build_packet(8'h05, 8'h00);
        expect_packet(-1);
        stream = pkt;
        params = '{8'h7F};
        build_packet(8'h06, 8'h80);
        expect_packet(-1);
        stream = {stream, pkt};
        foreach (stream[i]) send_byte(stream[i], 1'b1);
        idle_bits(3);
        drain("back_to_back");

        // enable dropped after RSV: the rest of the packet is ignored silently
        load_example();
        send_pkt(-1, 4);
        bus.enable = 1'b0;
        for (int i = 4; i < pkt.size(); i++) send_byte(pkt[i], 1'b1);
        idle_bits(2);
        bus.enable = 1'b1;
        idle_bits(2);
        drain("enable_drop");
        send_good("after_enable_drop");

        // reset pulsed after ID
        load_example();
        send_pkt(-1, 5);
        reset = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clock);
        #1;
        check("reset_mid_data", {bus.status_id, bus.status_error, bus.status_value, bus.param_count}, 64'h0);
        check("reset_mid_pulses", 64'({bus.status_valid, bus.crc_error, bus.frame_error}), 64'h0);
        reset = 1'b0;
        idle_bits(3);
        send_good("after_reset");

        idle_bits(4);
        checking = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dynamixel_status_receiver.md
# dynamixel_status_receiver

Receives Dynamixel Protocol 2.0 status packets from the half-duplex servo bus and presents the decoded ID, error byte and first parameter bytes to the controller. Sits directly downstream of the sync-write transmitter on the same bus pin. It listens only while the transmitter is not driving the bus, and it turns the replies to read instructions into register values. It contains an 8N1 UART receiver, a header/length parser and a CRC-16 checker.

## Interface
- clocks_per_bit, default 3: clock cycles per bus bit (12 MHz / 4 Mbaud); minimum 3.
- timeout_bits, default 100: idle bit-times inside a packet before the packet is aborted.
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- pin  input  1  bus line (tri-state input side), idle high, asynchronous to clock.
- enable  input  1  high = listen; low = receiver and parser held in idle/header hunt (drive low while transmitting).
- status_valid  output  1  one-cycle pulse: good packet decoded.
- status_id  output  8  ID of last good packet.
- status_error  output  8  error byte of last good packet.
- status_value  output  32  first up to 4 parameter bytes, little-endian, unused upper bytes 0.
- param_count  output  16  number of parameter bytes (after unstuffing).
- crc_error  output  1  one-cycle pulse: CRC mismatch.
- frame_error  output  1  one-cycle pulse: stop-bit, timeout, length or instruction error.

## Operation
- All outputs reset to 0. Data outputs change only on status_valid and hold until the next good packet.
- pin passes through a 2-flop synchronizer. This adds 2 cycles of latency.
- UART: a falling edge in idle starts a bit counter. The start bit is re-sampled at clocks_per_bit/2 (integer). A high sample there is a false start: return to idle with no error. Data bits are sampled every clocks_per_bit cycles, LSB first. The stop bit is sampled mid-bit. A low stop bit gives frame_error and resets the parser to HDR1. A byte strobe fires at the stop-bit sample.
- Parser states: HDR1(FF) → HDR2(FF) → HDR3(FD) → RSV(00) → ID → LEN_L → LEN_H → INST → ERR → PARAM → CRC_L → CRC_H.
  - In HDR1–RSV, a mismatching byte returns the parser to HDR1. The exception is FF received in HDR3, which stays in HDR3.
  - In INST, a byte other than 0x55 gives frame_error and HDR1.
  - A LEN value below 4 gives frame_error and HDR1.
  - LEN counts transmitted bytes from INST through CRC_H. ERR is entered after INST. PARAM consumes LEN−4 transmitted bytes; LEN=4 skips PARAM.
- CRC: polynomial 0x8005, init 0x0000, MSB-first, no reflection, no final XOR. It is computed over every transmitted byte from the first header FF through the last PARAM byte. The received CRC is {CRC_H, CRC_L}.
- Completion at the CRC_H strobe:
  - CRC match: status_valid.
  - CRC mismatch: crc_error.
  - Either way the parser returns to HDR1.
- Parameter bytes beyond 4 are counted in param_count but not stored.
- Timeout: the counter is cleared on every byte strobe. If the parser is not in HDR1 and timeout_bits×clocks_per_bit cycles pass with no strobe, pulse frame_error and go to HDR1.
- Deasserting enable mid-packet silently aborts the packet to HDR1 and the UART to idle. No error pulse is produced.
- Asserting reset mid-packet discards the packet and clears all outputs.

## Timing
- status_valid, crc_error and frame_error assert exactly 1 cycle after the internal byte strobe that triggers them. That strobe is the stop-bit sample of the final or offending byte.
- status_id, status_error, status_value and param_count are valid in the same cycle as status_valid.
- Only one error or valid pulse is produced per packet. A stop-bit error takes priority over a CRC result on the same byte.
- Back-to-back packets with zero idle gap are accepted. The parser is in HDR1 before the next start bit's mid-sample.

## Configuration
- DYNAMIXEL_RX_UNSTUFF_EN defined:
  - In PARAM, an FD byte that follows a transmitted FF FF FD sequence is a stuffing byte.
  - The stuffing byte is included in the CRC and consumes LEN.
  - It is not stored and not counted in param_count.
- Undefined: every PARAM byte is stored and counted, and param_count = LEN−4.

## Test plan
- Packet FF FF FD 00 01 07 00 55 00 06 04 26 65 5D → status_valid; id 0x01, error 0x00, param_count 3, status_value 0x00260406.
- Same packet with CRC byte 65 changed to 64 → crc_error pulse; no status_valid; outputs keep previous values.
- Stop bit forced low on the ID byte, then the good packet → frame_error once; the following packet is decoded correctly.
- Gap of 101 bit-times after LEN_H → frame_error; a subsequent good packet is accepted.
- Status packet with params FF FF FD FD 10 and CRC from the bench model:
  - Macro defined → param_count 4, status_value 0x10FDFFFF.
  - Macro undefined → param_count 5, status_value 0xFDFDFFFF.
- enable dropped after RSV, and separately reset pulsed after ID → no pulses; the next good packet decodes; after reset all outputs are 0.
